// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
package instr_fetch_unit_pkg;

  typedef enum logic [0:0] {
    IFU_IDLE  = 1'b0,
    IFU_FETCH = 1'b1
  } ifu_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low address bits are discarded.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - redirect, instruction memory and decode handshake bundle
interface instr_fetch_unit_if;

  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instruction_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  // Fetch unit side
  modport master (
    input  redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    output imem_req_o, imem_addr_o, instr_valid_o, instruction_o, instr_pc_o
  );

  // Memory / decode / redirect source side
  modport slave (
    output redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    input  imem_req_o, imem_addr_o, instr_valid_o, instruction_o, instr_pc_o
  );

endinterface

// File: rtl/instr_fetch_unit_fetch_queue.sv
// rtl/instr_fetch_unit_fetch_queue.sv - in-order queue of fetched {pc, instr} entries
module instr_fetch_unit_fetch_queue
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output fetch_entry_t     head_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CNT_W'(DEPTH)) || do_pop);

  // Pointer and occupancy next state; flush wins over push and pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - IF stage: word fetch, response queueing and redirect flush
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned DEPTH    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  ifu_state_e       state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] discard_q, discard_d;

  logic [CNT_W-1:0] q_cnt;
  logic             q_empty;
  fetch_entry_t     q_head;
  fetch_entry_t     q_push_data;

  logic             req;
  logic             grant;
  logic             resp;
  logic             push;
  logic             pop;
  logic [31:0]      redirect_pc;

  assign redirect_pc = word_align(bus.redirect_pc_i);

  // Responses only count against requests actually outstanding.
  assign resp  = bus.imem_rvalid_i && (inflight_q != '0);
  assign grant = req && bus.imem_gnt_i;
  assign push  = resp && (discard_q == '0) && !bus.redirect_i;
  assign pop   = !q_empty && bus.instr_ready_i && !bus.redirect_i;

  assign q_push_data = '{pc: resp_pc_q, instr: bus.imem_rdata_i};

  // FSM next state and request generation; credit uses registered counts only.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    case (state_q)
      IFU_IDLE:  state_d = IFU_FETCH;
      IFU_FETCH: begin
        state_d = IFU_FETCH;
        req     = !bus.redirect_i &&
                  (({1'b0, q_cnt} + {1'b0, inflight_q}) < SUM_W'(DEPTH));
      end
      default:   state_d = IFU_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IFU_IDLE;
    else        state_q <= state_d;
  end

  // PC and outstanding-request bookkeeping; redirect overrides everything.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    if (bus.redirect_i) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      inflight_d = inflight_q - CNT_W'(resp);
      discard_d  = inflight_q - CNT_W'(resp);
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)  resp_pc_d  = resp_pc_q + 32'd4;
      inflight_d = inflight_q + CNT_W'(grant) - CNT_W'(resp);
      if (resp && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
    end
  end

  // PC and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  instr_fetch_unit_fetch_queue #(
    .DEPTH (DEPTH)
  ) u_fetch_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (q_push_data),
    .pop_i       (pop),
    .flush_i     (bus.redirect_i),
    .count_o     (q_cnt),
    .empty_o     (q_empty),
    .head_o      (q_head)
  );

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = fetch_pc_q;
  assign bus.instr_valid_o = !q_empty;
  assign bus.instruction_o = q_empty ? NOP_INSTR : q_head.instr;
  assign bus.instr_pc_o    = q_empty ? resp_pc_q : q_head.pc;

endmodule
